// File: rtl/eth_defs.sv
// rtl/eth_defs.sv - eth_axi4lite register map plus rx reader state and phase encodings
package eth_defs;

    localparam logic [31:0] ETH_RX     = 32'h0000_0000;
    localparam logic [31:0] ETH_STATUS = 32'h0000_0008;

    localparam int unsigned STAT_RXEMPTY_BIT = 0;
    localparam int unsigned STAT_RXRESET_BIT = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT_AR,
        ST_STAT_R,
        ST_GAP,
        ST_DATA_AR,
        ST_DATA_R,
        ST_ABORT
    } rx_state_e;

    typedef enum logic [1:0] {
        PH_LEN_HI,
        PH_LEN_LO,
        PH_PAYLOAD
    } rx_phase_e;

endpackage

// File: rtl/eth_rx_stream_reg.sv
// rtl/eth_rx_stream_reg.sv - one-entry valid/ready output register carrying data, last and err
module eth_rx_stream_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    input  logic       err_i,
    output logic       full_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       last_o,
    output logic       err_o,
    input  logic       ready_i
);

    logic       valid_q;
    logic [7:0] data_q;
    logic       last_q;
    logic       err_q;

    // The reader only loads while empty, so load never collides with a pending beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            err_q   <= err_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    assign full_o  = valid_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: rtl/eth_axi4lite_rx_reader.sv
// rtl/eth_axi4lite_rx_reader.sv - AXI4-lite initiator draining the eth RX FIFO into a framed byte stream
module eth_axi4lite_rx_reader
    import eth_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned MAX_LEN   = 1536
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    output logic        m_arvalid_o,
    output logic [31:0] m_araddr_o,
    input  logic        m_arready_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    output logic        m_rready_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    output logic        out_last_o,
    output logic        out_err_o,
    input  logic        out_ready_i,
    output logic [15:0] pkt_count_o,
    output logic [15:0] abort_count_o
);

    rx_state_e   state_q;
    rx_phase_e   phase_q;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        rready_q;
    logic [15:0] gap_q;
    logic [7:0]  len_hi_q;
    logic [15:0] remain_q;
    logic        started_q;
    logic [15:0] abort_cnt_q;
    logic [15:0] pkt_cnt_q;

    logic        capture;
    logic        rresp_ok;
    logic [15:0] hdr_len;
    logic        pay_load;
    logic        abort_load;
    logic        stream_full;
    logic        unused_rdata;

    assign capture      = m_rvalid_i && rready_q;
    assign rresp_ok     = (m_rresp_i == AXI_RESP_OKAY);
    assign hdr_len      = {len_hi_q, m_rdata_i[7:0]};
    assign pay_load     = (state_q == ST_DATA_R) && capture && rresp_ok && (phase_q == PH_PAYLOAD);
    // A truncation beat is only owed once payload bytes have left the block.
    assign abort_load   = (state_q == ST_ABORT) && started_q && !stream_full;
    assign unused_rdata = ^m_rdata_i[31:8];

    eth_rx_stream_reg u_stream_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (pay_load || abort_load),
        .data_i  (abort_load ? 8'h00 : m_rdata_i[7:0]),
        .last_i  (abort_load || (remain_q == 16'd1)),
        .err_i   (abort_load),
        .full_o  (stream_full),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .last_o  (out_last_o),
        .err_o   (out_err_o),
        .ready_i (out_ready_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_LEN_HI;
            arvalid_q   <= 1'b0;
            araddr_q    <= 32'h0;
            rready_q    <= 1'b0;
            gap_q       <= 16'h0;
            len_hi_q    <= 8'h00;
            remain_q    <= 16'h0;
            started_q   <= 1'b0;
            abort_cnt_q <= 16'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A packet already in flight finishes even when stopped.
                    if (enable_i || (phase_q != PH_LEN_HI)) begin
                        state_q   <= ST_STAT_AR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= BASE_ADDR + ETH_STATUS;
                    end
                end
                ST_STAT_AR, ST_DATA_AR: begin
                    if (m_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == ST_STAT_AR) ? ST_STAT_R : ST_DATA_R;
                    end
                end
                ST_STAT_R: begin
                    if (capture) begin
                        rready_q <= 1'b0;
                        if (!rresp_ok || m_rdata_i[STAT_RXRESET_BIT]) begin
                            state_q <= ST_ABORT;
                        end else if (m_rdata_i[STAT_RXEMPTY_BIT]) begin
                            state_q <= ST_GAP;
                            gap_q   <= 16'(POLL_GAP);
                        end else if (stream_full) begin
                            state_q   <= ST_STAT_AR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_DATA_AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= BASE_ADDR + ETH_RX;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == 16'h0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                ST_DATA_R: begin
                    if (capture) begin
                        rready_q  <= 1'b0;
                        state_q   <= ST_STAT_AR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= BASE_ADDR + ETH_STATUS;
                        if (!rresp_ok) begin
                            state_q   <= ST_ABORT;
                            arvalid_q <= 1'b0;
                        end else begin
                            case (phase_q)
                                PH_LEN_HI: begin
                                    len_hi_q <= m_rdata_i[7:0];
                                    phase_q  <= PH_LEN_LO;
                                end
                                PH_LEN_LO: begin
                                    if (hdr_len == 16'h0) begin
                                        phase_q <= PH_LEN_HI;
                                    end else if (32'(hdr_len) > MAX_LEN) begin
                                        state_q   <= ST_ABORT;
                                        arvalid_q <= 1'b0;
                                    end else begin
                                        remain_q <= hdr_len;
                                        phase_q  <= PH_PAYLOAD;
                                    end
                                end
                                default: begin
                                    remain_q <= remain_q - 16'd1;
                                    if (remain_q == 16'd1) begin
                                        phase_q   <= PH_LEN_HI;
                                        started_q <= 1'b0;
                                    end else begin
                                        started_q <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_ABORT: begin
                    if (!started_q || !stream_full) begin
                        abort_cnt_q <= abort_cnt_q + 16'd1;
                        phase_q     <= PH_LEN_HI;
                        started_q   <= 1'b0;
                        state_q     <= ST_GAP;
                        gap_q       <= 16'(POLL_GAP);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q <= 16'h0;
        end else if (out_valid_o && out_ready_i && out_last_o && !out_err_o) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign m_arvalid_o   = arvalid_q;
    assign m_araddr_o    = araddr_q;
    assign m_rready_o    = rready_q;
    assign pkt_count_o   = pkt_cnt_q;
    assign abort_count_o = abort_cnt_q;

endmodule
